// File: rtl/vx_pending_ctrl.sv
// vx_pending_ctrl
// ---------------
// Per-warp in-flight instruction tracker and issue gate. It sits between the
// issue stage and the commit/scheduler path.
// - It counts the instructions issued to each warp.
// - It retires them on the per-slot commit pulses.
// - It refuses issue while a warp is at its in-flight limit or being drained.
// - It gives each warp a drain (fence) handshake that reports when all of that
//   warp's outstanding instructions have committed.
//
// Optional build macro: PENDING_PERF_EN
//   defined   -> perf_issue_stalls counts the cycles in which issue was refused
//                (saturating at all-ones).
//   undefined -> perf_issue_stalls is tied to zero and no counter is built.
//
// Ports:
//   clk               clock
//   reset             synchronous active-high reset
//   issue_valid       issue request
//   issue_wid         warp of the issue request
//   issue_ready       issue accepted this cycle (combinational; independent of issue_valid)
//   commit_valid      per-slot commit pulse, ISSUE_WIDTH slots
//   commit_wid        per-slot committed warp id, packed ISSUE_WIDTH x NW_W
//   drain_req         per-warp level drain request, held until drain_done
//   drain_done        per-warp one-cycle pulse: warp fully drained
//   pending_busy      per-warp: registered count is non-zero
//   pending_full      per-warp: registered count is at the limit
//   underflow_err     sticky: a commit arrived for a warp with nothing pending
//   perf_issue_stalls refused-issue cycle counter (see macro above)

module vx_pending_ctrl #(
    parameter int NUM_WARPS     = 4,
    parameter int ISSUE_WIDTH   = 1,
    parameter int CTR_W         = 4,
    parameter int NW_W          = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    parameter int PERF_CTR_BITS = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    input  logic [NW_W-1:0]               issue_wid,
    output logic                          issue_ready,
    input  logic [ISSUE_WIDTH-1:0]        commit_valid,
    input  logic [ISSUE_WIDTH*NW_W-1:0]   commit_wid,
    input  logic [NUM_WARPS-1:0]          drain_req,
    output logic [NUM_WARPS-1:0]          drain_done,
    output logic [NUM_WARPS-1:0]          pending_busy,
    output logic [NUM_WARPS-1:0]          pending_full,
    output logic                          underflow_err,
    output logic [PERF_CTR_BITS-1:0]      perf_issue_stalls
);

    localparam int DEC_W = $clog2(ISSUE_WIDTH + 1);
    localparam int SUM_W = CTR_W + DEC_W + 1;
    localparam logic [CTR_W-1:0] MAX_PEND = '1;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_WAIT,
        DR_DONE
    } drain_state_e;

    logic [CTR_W-1:0]     cnt_q   [NUM_WARPS];
    logic [CTR_W-1:0]     cnt_d   [NUM_WARPS];
    logic [SUM_W-1:0]     sum     [NUM_WARPS];
    drain_state_e         drain_q [NUM_WARPS];
    logic [NUM_WARPS-1:0] drain_done_q;
    logic                 underflow_q;
    logic                 underflow_d;
    logic [NUM_WARPS-1:0] inc;
    logic [DEC_W-1:0]     dec     [NUM_WARPS];
    logic                 selRoom;
    logic                 selIdle;
    logic                 issueFire;

    // Look up the addressed warp with a compare loop rather than a direct
    // index. This keeps a non-power-of-two warp count from reading past the
    // array; an out-of-range warp id is simply never ready.
    always_comb begin
        selRoom = 1'b0;
        selIdle = 1'b0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            if (issue_wid == NW_W'(w)) begin
                selRoom = (cnt_q[w] != MAX_PEND);
                selIdle = (drain_q[w] == DR_IDLE);
            end
        end
    end

    // The gate looks only at the registered count. A commit in the same cycle
    // does not free a slot until the next cycle, so the gate is conservative.
    assign issue_ready = !reset && selRoom && selIdle;
    assign issueFire   = issue_valid && issue_ready;

    // Per-warp increment from the issue fire. The decrement is a popcount of
    // the commit slots whose warp id matches.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            inc[w] = issueFire && (issue_wid == NW_W'(w));
            dec[w] = '0;
            for (int i = 0; i < ISSUE_WIDTH; i++) begin
                if (commit_valid[i] && (commit_wid[i*NW_W +: NW_W] == NW_W'(w))) begin
                    dec[w] = dec[w] + DEC_W'(1);
                end
            end
        end
    end

    // Next count is formed at a wider width so that cnt + inc - dec can be
    // checked for underflow. An underflowing warp clamps to zero and raises
    // the sticky error. Overflow cannot happen: inc needs issue_ready, and
    // issue_ready needs the count below the limit.
    always_comb begin
        underflow_d = underflow_q;
        for (int w = 0; w < NUM_WARPS; w++) begin
            sum[w] = SUM_W'(cnt_q[w]) + SUM_W'(inc[w]);
            if (sum[w] < SUM_W'(dec[w])) begin
                cnt_d[w]    = '0;
                underflow_d = 1'b1;
            end else begin
                cnt_d[w] = CTR_W'(sum[w] - SUM_W'(dec[w]));
            end
        end
    end

    // Counters, the sticky error and the per-warp drain FSMs.
    // WAIT completes only on a cycle that is quiet for this warp: the count is
    // zero and nothing is issuing to it or committing from it. drain_done is
    // registered on the WAIT->DONE transition, so it is high exactly while
    // the warp sits in DONE. Reset drops any drain in progress without a pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w]   <= '0;
                drain_q[w] <= DR_IDLE;
            end
            drain_done_q <= '0;
            underflow_q  <= 1'b0;
        end else begin
            underflow_q <= underflow_d;
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w]        <= cnt_d[w];
                drain_done_q[w] <= 1'b0;
                case (drain_q[w])
                    DR_IDLE: begin
                        if (drain_req[w]) begin
                            drain_q[w] <= DR_WAIT;
                        end
                    end
                    DR_WAIT: begin
                        if (!drain_req[w]) begin
                            drain_q[w] <= DR_IDLE;
                        end else if ((cnt_q[w] == '0) && !inc[w] && (dec[w] == '0)) begin
                            drain_q[w]      <= DR_DONE;
                            drain_done_q[w] <= 1'b1;
                        end
                    end
                    DR_DONE: begin
                        drain_q[w] <= DR_IDLE;
                    end
                    default: begin
                        drain_q[w] <= DR_IDLE;
                    end
                endcase
            end
        end
    end

    // Status flags are decoded from the registered count. They therefore lag
    // a counter update by one cycle.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_busy[w] = (cnt_q[w] != '0);
            pending_full[w] = (cnt_q[w] == MAX_PEND);
        end
    end

    assign drain_done    = drain_done_q;
    assign underflow_err = underflow_q;

`ifdef PENDING_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_q;

    // Count the cycles in which a request was refused. issue_ready is
    // already low during reset, but the reset branch takes priority anyway.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (issue_valid && !issue_ready && (perf_q != '1)) begin
            perf_q <= perf_q + PERF_CTR_BITS'(1);
        end
    end

    assign perf_issue_stalls = perf_q;
`else
    assign perf_issue_stalls = '0;
`endif

endmodule

// File: doc/vx_pending_ctrl.md
Name: vx_pending_ctrl

Overview:
Per-warp in-flight instruction tracker and issue gate between the issue stage and the commit/scheduler path.
- Counts instructions issued per warp and retires them on the registered per-slot committed/committed_wid pulses from commit.
- Throttles issue when a warp's in-flight count reaches its limit.
- Provides a per-warp drain (fence) handshake that signals when all outstanding instructions of a warp have committed.

Parameters:
NUM_WARPS, 4, number of warps tracked
ISSUE_WIDTH, 1, number of commit slots that can retire in one cycle
CTR_W, 4, counter width per warp; limit MAX_PEND = 2^CTR_W - 1
NW_W, CLOG2(NUM_WARPS) min 1, warp-id width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
issue_valid  in  1  issue request
issue_wid  in  NW_W  warp of issue request
issue_ready  out  1  issue accepted this cycle (fire = valid & ready)
commit_valid  in  ISSUE_WIDTH  per-slot committed pulse
commit_wid  in  ISSUE_WIDTH*NW_W  per-slot committed warp id
drain_req  in  NUM_WARPS  level request to drain warp w; held until drain_done
drain_done  out  NUM_WARPS  one-cycle pulse: warp drained
pending_busy  out  NUM_WARPS  cnt[w] != 0
pending_full  out  NUM_WARPS  cnt[w] == MAX_PEND
underflow_err  out  1  sticky: a commit arrived with nothing pending
perf_issue_stalls  out  PERF_CTR_BITS  stall counter (see Optional Feature)

Behaviour:
Clock and reset:
- One clock, clk; reset is synchronous, active-high.
- Reset clears all cnt to 0, all drain FSMs to IDLE, underflow_err, drain_done and perf_issue_stalls to 0.
- While reset is high, issue_ready = 0.
- Reset mid-drain abandons the drain with no drain_done pulse.

Issue gating:
- issue_ready (combinational) = !reset & (cnt[issue_wid] < MAX_PEND) & (drain_state[issue_wid] == IDLE).
- Commits in the same cycle do not raise the limit; the gate is conservative.
- issue_ready does not depend on issue_valid.

Counter update, per warp w, each cycle:
- inc = issue fire with issue_wid == w (0 or 1).
- dec = popcount of slots i with commit_valid[i] & commit_wid[i] == w (0..ISSUE_WIDTH).
- cnt_next = cnt + inc - dec, computed at CTR_W+CLOG2(ISSUE_WIDTH+1)+1 bits.
- If cnt + inc < dec: cnt_next = 0 and underflow_err is set, sticky until reset.
- Simultaneous inc and dec at MAX_PEND nets correctly; cnt never exceeds MAX_PEND and never wraps.
- pending_busy and pending_full are decoded from registered cnt, so they lag the update by 1 cycle.

Drain FSM, per warp: IDLE -> WAIT -> DONE -> IDLE.
- IDLE -> WAIT when drain_req[w].
- WAIT: issue to w is blocked. Move to DONE when the registered cnt[w] == 0 and no inc/dec is occurring that cycle.
- DONE: drain_done[w] = 1 for exactly one cycle, then IDLE.
- A request on an already-idle warp (cnt = 0) pulses drain_done 2 cycles after drain_req rises.
- If drain_req[w] is still high after the IDLE return, a new drain starts. The requester must drop it on drain_done.
- drain_req deasserted during WAIT returns the warp to IDLE with no pulse.
- Drain FSMs of different warps are independent.

Optional Feature:
PENDING_PERF_EN
- Defined: perf_issue_stalls increments by 1 each cycle issue_valid & !issue_ready & !reset, saturating at all-ones.
- Undefined: perf_issue_stalls is tied to 0 and the counter logic is not built.

Test Plan:
- Reset, then 3 issues to wid 1 and no commits -> cnt[1] = 3, pending_busy = 4'b0010, issue_ready stays 1.
- CTR_W = 2: issue wid 0 four times back-to-back -> the 4th is refused (issue_ready = 0), pending_full[0] = 1; one commit for wid 0 -> issue_ready = 1 the next cycle.
- ISSUE_WIDTH = 2, cnt[2] = 2: both slots commit wid 2 while wid 2 issues -> cnt[2] = 1 next cycle.
- cnt[3] = 2, assert drain_req[3] -> issue to wid 3 blocked; two commits -> drain_done[3] pulses exactly once, 1 cycle after cnt reaches 0. drain_req on idle wid 0 -> drain_done[0] 2 cycles later.
- Commit wid 1 with cnt[1] = 0 -> cnt stays 0, underflow_err = 1 and stays set until reset.
- PENDING_PERF_EN defined: issue_valid held 5 cycles on a full warp -> perf_issue_stalls = 5. Macro undefined -> perf_issue_stalls = 0.
